reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file_read_port.sv | 44 ++++
 rtl/reg_file.sv | 89 ++++++++
 tb/tb_reg_file.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file: register count,
// register-id width, the hard-wired zero register and the default ROB index width.
package reg_file_pkg;

    localparam int ROB_SIZE_LOG = 4;
    localparam int REG_NUM      = 32;
    localparam int REG_ID_W     = $clog2(REG_NUM);

    localparam logic [REG_ID_W-1:0] ZERO_REG = '0;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational operand lookup: returns busy/tag/value for a register,
// forwarding a same-cycle commit that retires the pending producer.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int ROB_W = ROB_SIZE_LOG,
    parameter int XLEN  = 32
) (
    input  logic [REG_ID_W-1:0] regid,
    input  logic [REG_NUM-1:0]  busy_q,
    input  logic [ROB_W-1:0]    tag_q   [REG_NUM],
    input  logic [XLEN-1:0]     value_q [REG_NUM],
    input  logic                commit_enable,
    input  logic [REG_ID_W-1:0] commit_regid,
    input  logic [ROB_W-1:0]    commit_robid,
    input  logic [XLEN-1:0]     commit_value,
    output logic                busy,
    output logic [ROB_W-1:0]    robid,
    output logic [XLEN-1:0]     value
);

    logic commit_hit;

    assign commit_hit = commit_enable
                     && (commit_regid == regid)
                     && busy_q[regid]
                     && (tag_q[regid] == commit_robid);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        busy  = busy_q[regid];
        robid = tag_q[regid];
        value = value_q[regid];
        if (regid == ZERO_REG) begin
            busy  = 1'b0;
            robid = '0;
            value = '0;
        end else if (commit_hit) begin
            busy  = 1'b0;
            value = commit_value;
        end
    end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// Architectural register file with ROB-tag renaming: records renames at issue,
// retires values on ROB commit, and drops outstanding renames on a flush.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_W = ROB_SIZE_LOG,
    parameter int XLEN  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                commit_enable,
    input  logic [REG_ID_W-1:0] commit_regid,
    input  logic [XLEN-1:0]     commit_value,
    input  logic [ROB_W-1:0]    commit_robid,
    input  logic                rename_enable,
    input  logic [REG_ID_W-1:0] rename_regid,
    input  logic [ROB_W-1:0]    rename_robid,
    input  logic [REG_ID_W-1:0] rs1_regid,
    input  logic [REG_ID_W-1:0] rs2_regid,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [ROB_W-1:0]    rs1_robid,
    output logic [ROB_W-1:0]    rs2_robid,
    output logic [XLEN-1:0]     rs1_value,
    output logic [XLEN-1:0]     rs2_value
);

    logic [REG_NUM-1:0] busy_q;
    logic [ROB_W-1:0]   tag_q   [REG_NUM];
    logic [XLEN-1:0]    value_q [REG_NUM];

    // Sub-steps run in order; a later assignment to the same bit wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the value array is reset too, because every read after reset must return 0.
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_q[i]   <= '0;
                value_q[i] <= '0;
            end
        end else if (rdy) begin
            // NOTE: non-blocking so every condition below sees the pre-edge state.
            if (commit_enable && (commit_regid != ZERO_REG)) begin
                value_q[commit_regid] <= commit_value;
                if (busy_q[commit_regid] && (tag_q[commit_regid] == commit_robid)) begin
                    busy_q[commit_regid] <= 1'b0;
                end
            end
            if (rename_enable && (rename_regid != ZERO_REG) && !flush) begin
                busy_q[rename_regid] <= 1'b1;
                tag_q[rename_regid]  <= rename_robid;
            end
            if (flush) begin
                busy_q <= '0;
            end
        end
    end

    reg_file_read_port #(.ROB_W(ROB_W), .XLEN(XLEN)) u_rs1 (
        .regid         (rs1_regid),
        .busy_q        (busy_q),
        .tag_q         (tag_q),
        .value_q       (value_q),
        .commit_enable (commit_enable),
        .commit_regid  (commit_regid),
        .commit_robid  (commit_robid),
        .commit_value  (commit_value),
        .busy          (rs1_busy),
        .robid         (rs1_robid),
        .value         (rs1_value)
    );

    reg_file_read_port #(.ROB_W(ROB_W), .XLEN(XLEN)) u_rs2 (
        .regid         (rs2_regid),
        .busy_q        (busy_q),
        .tag_q         (tag_q),
        .value_q       (value_q),
        .commit_enable (commit_enable),
        .commit_regid  (commit_regid),
        .commit_robid  (commit_robid),
        .commit_value  (commit_value),
        .busy          (rs2_busy),
        .robid         (rs2_robid),
        .value         (rs2_value)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected read-port results are queued as stimulus
// is applied and popped when the ports are sampled.
module tb_reg_file;

    localparam int ROB_W = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             flush;
    logic             commit_enable;
    logic [4:0]       commit_regid;
    logic [XLEN-1:0]  commit_value;
    logic [ROB_W-1:0] commit_robid;
    logic             rename_enable;
    logic [4:0]       rename_regid;
    logic [ROB_W-1:0] rename_robid;
    logic [4:0]       rs1_regid;
    logic [4:0]       rs2_regid;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [ROB_W-1:0] rs1_robid;
    logic [ROB_W-1:0] rs2_robid;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string            tag;
        int               port;
        logic             busy;
        logic [ROB_W-1:0] robid;
        bit               chk_robid;
        logic [XLEN-1:0]  value;
    } exp_t;

    exp_t sb[$];

    always #10 clk = ~clk;

    reg_file #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .commit_enable (commit_enable),
        .commit_regid  (commit_regid),
        .commit_value  (commit_value),
        .commit_robid  (commit_robid),
        .rename_enable (rename_enable),
        .rename_regid  (rename_regid),
        .rename_robid  (rename_robid),
        .rs1_regid     (rs1_regid),
        .rs2_regid     (rs2_regid),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_robid     (rs1_robid),
        .rs2_robid     (rs2_robid),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_port(input string tag, input int port, input logic b,
                               input logic [ROB_W-1:0] r, input bit cr, input logic [XLEN-1:0] v);
        exp_t e;
        e.tag = tag; e.port = port; e.busy = b; e.robid = r; e.chk_robid = cr; e.value = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t             e;
        logic             ob;
        logic [ROB_W-1:0] orid;
        logic [XLEN-1:0]  ov;
        #1;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            ob   = (e.port == 1) ? rs1_busy  : rs2_busy;
            orid = (e.port == 1) ? rs1_robid : rs2_robid;
            ov   = (e.port == 1) ? rs1_value : rs2_value;
            total++;
            if (e.chk_robid) begin
                assert ({ob, orid, ov} === {e.busy, e.robid, e.value}) else begin
                    bad++;
                    $display("FAIL %s: got busy=%0b robid=%0d value=%h, want busy=%0b robid=%0d value=%h",
                             e.tag, ob, orid, ov, e.busy, e.robid, e.value);
                    $error("comparison %s", e.tag);
                end
            end else begin
                assert ({ob, ov} === {e.busy, e.value}) else begin
                    bad++;
                    $display("FAIL %s: got busy=%0b value=%h, want busy=%0b value=%h",
                             e.tag, ob, ov, e.busy, e.value);
                    $error("comparison %s", e.tag);
                end
            end
        end
    endtask

    task automatic idle();
        flush = 1'b0; commit_enable = 1'b0; rename_enable = 1'b0;
    endtask

    task automatic do_commit(input logic [4:0] id, input logic [ROB_W-1:0] rob, input logic [XLEN-1:0] v);
        commit_enable = 1'b1; commit_regid = id; commit_robid = rob; commit_value = v;
    endtask

    task automatic do_rename(input logic [4:0] id, input logic [ROB_W-1:0] rob);
        rename_enable = 1'b1; rename_regid = id; rename_robid = rob;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; idle();
        commit_regid = '0; commit_value = '0; commit_robid = '0;
        rename_regid = '0; rename_robid = '0;
        rs1_regid = '0; rs2_regid = '0;
        tick(); tick();
        rst = 1'b1;

        rs1_regid = 5; rs2_regid = 31;
        expect_port("rst_x5", 1, 1'b0, 0, 1, 32'h0);
        expect_port("rst_x31", 2, 1'b0, 0, 1, 32'h0);
        check();

        // Writes to x0 are ignored and never bypassed
        do_commit(0, 0, 32'hDEAD);
        rs1_regid = 0;
        expect_port("x0_bypass", 1, 1'b0, 0, 1, 32'h0);
        check();
        tick(); idle();
        expect_port("x0_state", 1, 1'b0, 0, 1, 32'h0);
        check();

        do_rename(3, 2);
        rs2_regid = 3;
        expect_port("rename_invisible", 2, 1'b0, 0, 1, 32'h0);
        check();
        tick(); idle();
        rs1_regid = 3;
        expect_port("x3_busy", 1, 1'b1, 2, 1, 32'h0);
        check();
        do_commit(3, 2, 32'h1234);
        expect_port("x3_bypass", 1, 1'b0, 0, 0, 32'h1234);
        check();
        tick(); idle();
        expect_port("x3_state", 1, 1'b0, 2, 1, 32'h1234);
        check();

        // Stale commit from an older rename keeps the younger mapping
        do_rename(4, 1); tick();
        do_rename(4, 5); tick(); idle();
        do_commit(4, 1, 32'h7);
        rs1_regid = 4;
        expect_port("x4_no_bypass", 1, 1'b1, 5, 1, 32'h0);
        check();
        tick(); idle();
        expect_port("x4_stale_commit", 1, 1'b1, 5, 1, 32'h7);
        check();
        do_commit(4, 5, 32'h9);
        expect_port("x4_bypass", 1, 1'b0, 0, 0, 32'h9);
        check();
        tick(); idle();
        expect_port("x4_retired", 1, 1'b0, 5, 1, 32'h9);
        check();

        do_rename(6, 3); tick(); idle();
        do_commit(6, 3, 32'hAA);
        do_rename(6, 7);
        rs1_regid = 6;
        expect_port("x6_same_cycle_bypass", 1, 1'b0, 0, 0, 32'hAA);
        check();
        tick(); idle();
        expect_port("x6_rename_wins", 1, 1'b1, 7, 1, 32'hAA);
        check();

        // Flush with concurrent commit and a discarded rename
        do_rename(1, 1); tick();
        do_rename(2, 2); tick();
        do_rename(9, 9); tick(); idle();
        do_rename(10, 4);
        do_commit(1, 1, 32'h55);
        flush = 1'b1;
        rs1_regid = 1;
        expect_port("x1_flush_bypass", 1, 1'b0, 0, 0, 32'h55);
        check();
        tick(); idle();
        rs1_regid = 1; rs2_regid = 2;
        expect_port("x1_after_flush", 1, 1'b0, 1, 1, 32'h55);
        expect_port("x2_after_flush", 2, 1'b0, 2, 1, 32'h0);
        check();
        rs1_regid = 9; rs2_regid = 10;
        expect_port("x9_after_flush", 1, 1'b0, 9, 1, 32'h0);
        expect_port("x10_discarded", 2, 1'b0, 0, 1, 32'h0);
        check();
        rs1_regid = 6;
        expect_port("x6_after_flush", 1, 1'b0, 7, 1, 32'hAA);
        check();

        // rdy=0 freezes state but the bypass stays live
        do_rename(8, 6); tick(); idle();
        rdy = 1'b0;
        do_commit(8, 6, 32'h1);
        do_rename(12, 3);
        rs1_regid = 8; rs2_regid = 12;
        expect_port("x8_bypass_rdy0", 1, 1'b0, 0, 0, 32'h1);
        expect_port("x12_rdy0", 2, 1'b0, 0, 1, 32'h0);
        check();
        tick(); tick(); idle();
        expect_port("x8_frozen", 1, 1'b1, 6, 1, 32'h0);
        check();
        rdy = 1'b1;
        tick();
        expect_port("x8_after_rdy", 1, 1'b1, 6, 1, 32'h0);
        expect_port("x12_after_rdy", 2, 1'b0, 0, 1, 32'h0);
        check();

        // Reset overrides commit, rename and flush in the same cycle
        rst = 1'b0;
        do_commit(8, 6, 32'h3);
        do_rename(13, 2);
        flush = 1'b1;
        tick();
        rst = 1'b1; idle();
        rs1_regid = 8; rs2_regid = 3;
        expect_port("x8_reset", 1, 1'b0, 0, 1, 32'h0);
        expect_port("x3_reset", 2, 1'b0, 0, 1, 32'h0);
        check();
        rs1_regid = 13; rs2_regid = 4;
        expect_port("x13_reset", 1, 1'b0, 0, 1, 32'h0);
        expect_port("x4_reset", 2, 1'b0, 0, 1, 32'h0);
        check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file
